// File: rtl/sort_serializer.sv
// sort_serializer: buffers whole sorted vectors from a sorter with no backpressure and streams them
// out one element per transfer. Define SORT_SER_DESC_EN to emit each vector largest-first.
module sort_serializer #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int VEC_FIFO = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic signed [WIDTH-1:0]        sorted_in [DEPTH],
    output logic signed [WIDTH-1:0]        out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic [$clog2(DEPTH)-1:0]       out_index,
    output logic [$clog2(VEC_FIFO+1)-1:0]  vec_count,
    output logic                           overflow,
    output logic                           overflow_sticky
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(VEC_FIFO + 1);
    localparam int PW = (VEC_FIFO > 1) ? $clog2(VEC_FIFO) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(VEC_FIFO - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(VEC_FIFO);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    localparam logic [0:0] EMPTY  = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]              r_state;
    logic signed [WIDTH-1:0] r_mem [VEC_FIFO][DEPTH];
    logic [PW-1:0]           r_wrPtr;
    logic [PW-1:0]           r_rdPtr;
    logic [CW-1:0]           r_count;
    logic [IW-1:0]           r_index;
    logic                    r_sticky;

    logic                    w_xfer;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic [IW-1:0]           w_elem;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A full buffer still takes a vector when the head vector leaves in the same cycle.
    assign w_xfer = (r_state == STREAM) && out_ready;
    assign w_pop  = w_xfer && (r_index == LAST_IDX);
    assign w_push = valid_in && ((r_count < FULL_CNT) || w_pop);
    assign w_drop = valid_in && !w_push;

`ifdef SORT_SER_DESC_EN
    assign w_elem = ~r_index;
`else
    assign w_elem = r_index;
`endif

    assign out_valid       = (r_state == STREAM);
    assign out_data        = r_mem[r_rdPtr][w_elem];
    assign out_last        = out_valid && (r_index == LAST_IDX);
    assign out_index       = r_index;
    assign vec_count       = r_count;
    assign overflow        = w_drop;
    assign overflow_sticky = r_sticky;

    // Vector storage carries no reset; the control state alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= sorted_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= EMPTY;
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
            r_index  <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            if (w_xfer) begin
                r_index <= w_pop ? '0 : r_index + 1'b1;
            end
            if (w_drop) begin
                r_sticky <= 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase

            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state <= STREAM;
                    end
                end
                default: begin
                    if (w_pop && !w_push && (r_count == ONE_CNT)) begin
                        r_state <= EMPTY;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sort_serializer.sv
// Scoreboard bench for sort_serializer: expected elements are queued at push time and
// compared against every cycle of DUT output. Honours SORT_SER_DESC_EN like the design.
module tb_sort_serializer;
    localparam int WIDTH    = 32;
    localparam int DEPTH    = 8;
    localparam int VEC_FIFO = 2;
    localparam int IW       = $clog2(DEPTH);
    localparam int CW       = $clog2(VEC_FIFO + 1);

    typedef logic signed [WIDTH-1:0] vec_t [DEPTH];
    typedef struct {
        logic signed [WIDTH-1:0] data;
        logic [IW-1:0]           idx;
        logic                    last;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic                    valid_in;
    logic signed [WIDTH-1:0] sorted_in [DEPTH];
    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic [IW-1:0]           out_index;
    logic [CW-1:0]           vec_count;
    logic                    overflow;
    logic                    overflow_sticky;

    exp_t expQ[$];
    int   mCount;
    logic mSticky;
    int   compareCount;
    int   failCount;

    vec_t vecA, vecB, vecC, vecExt, vecZero, vecRnd;

    sort_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .VEC_FIFO(VEC_FIFO)) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .sorted_in(sorted_in),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .out_index(out_index),
        .vec_count(vec_count),
        .overflow(overflow),
        .overflow_sticky(overflow_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pushVector(input vec_t vec);
        exp_t e;
        for (int k = 0; k < DEPTH; k++) begin
`ifdef SORT_SER_DESC_EN
            e.data = vec[DEPTH-1-k];
`else
            e.data = vec[k];
`endif
            e.idx  = IW'(k);
            e.last = (k == DEPTH - 1);
            expQ.push_back(e);
        end
    endtask

    // One clock cycle: drive just after the rising edge, check and update the model at the falling edge.
    task automatic applyStimulus(input logic v, input vec_t vec, input logic rdy);
        exp_t front;
        logic popLast;
        logic accept;
        valid_in  = v;
        sorted_in = vec;
        out_ready = rdy;
        @(negedge clk);
        popLast = 1'b0;
        checkOutput("out_valid", out_valid, expQ.size() != 0);
        checkOutput("vec_count", vec_count, mCount);
        checkOutput("overflow_sticky", overflow_sticky, mSticky);
        if (expQ.size() != 0) begin
            front = expQ[0];
            checkOutput("out_data", out_data, front.data);
            checkOutput("out_index", out_index, front.idx);
            checkOutput("out_last", out_last, front.last);
            if (rdy) begin
                popLast = front.last;
                void'(expQ.pop_front());
            end
        end
        accept = v && ((mCount < VEC_FIFO) || popLast);
        checkOutput("overflow", overflow, v && !accept);
        if (accept) pushVector(vec);
        if (v && !accept) mSticky = 1'b1;
        mCount = mCount + int'(accept) - int'(popLast);
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic drainAll(input int mode);
        logic rdy;
        for (int c = 0; c < 400 && expQ.size() != 0; c++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            applyStimulus(1'b0, vecZero, rdy);
        end
        checkOutput("drained", expQ.size(), 0);
        applyStimulus(1'b0, vecZero, 1'b1);
    endtask

    initial begin
        logic done;
        compareCount = 0;
        failCount    = 0;
        mCount       = 0;
        mSticky      = 1'b0;
        vecA   = '{-10, -3, -1, 0, 2, 4, 5, 7};
        vecB   = '{-100, -50, -20, 1, 3, 8, 60, 99};
        vecC   = '{11, 12, 13, 14, 15, 16, 17, 18};
        vecExt = '{32'sh80000000, -123, -1, 0, 0, 1, 123, 32'sh7fffffff};
        vecZero = '{default: '0};
        rst       = 1'b0;
        valid_in  = 1'b0;
        out_ready = 1'b0;
        sorted_in = vecZero;

        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_out_index", out_index, 0);
        checkOutput("rst_vec_count", vec_count, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_sticky", overflow_sticky, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        $display("[TB] single vector");
        applyStimulus(1'b1, vecA, 1'b1);
        drainAll(0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, vecA, 1'b1);
        drainAll(1);

        $display("[TB] overflow");
        applyStimulus(1'b1, vecA, 1'b0);
        applyStimulus(1'b1, vecB, 1'b0);
        applyStimulus(1'b1, vecC, 1'b0);
        checkOutput("ovf_vec_count", vec_count, 2);
        checkOutput("ovf_sticky", overflow_sticky, 1);
        drainAll(0);

        $display("[TB] simultaneous push and pop");
        applyStimulus(1'b1, vecA, 1'b0);
        applyStimulus(1'b1, vecB, 1'b0);
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (expQ.size() != 0 && expQ[0].last && mCount == 2) begin
                applyStimulus(1'b1, vecC, 1'b1);
                checkOutput("simul_vec_count", vec_count, 2);
                done = 1'b1;
            end else begin
                applyStimulus(1'b0, vecZero, 1'b1);
            end
        end
        checkOutput("simul_reached", done, 1);
        drainAll(0);

        $display("[TB] extremes");
        applyStimulus(1'b1, vecExt, 1'b1);
        drainAll(0);

        $display("[TB] random traffic");
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < DEPTH; k++) vecRnd[k] = $urandom;
            applyStimulus($urandom_range(0, 3) == 0, vecRnd, 1'($urandom_range(0, 1)));
        end
        drainAll(2);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, vecA, 1'b1);
        repeat (3) applyStimulus(1'b0, vecZero, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_last", out_last, 0);
        checkOutput("midrst_out_index", out_index, 0);
        checkOutput("midrst_vec_count", vec_count, 0);
        checkOutput("midrst_overflow", overflow, 0);
        checkOutput("midrst_sticky", overflow_sticky, 0);
        expQ.delete();
        mCount  = 0;
        mSticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b0, vecZero, 1'b1);
        applyStimulus(1'b1, vecB, 1'b1);
        drainAll(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end
endmodule
